// File: rtl/registro_solicitudes.sv
// Request register and door timer for a four-floor elevator: latches hall/cabin
// calls, detects stops, and holds the door open while clearing the calls served at this floor.
module registro_solicitudes #(
  parameter int unsigned TIEMPO_PUERTA = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] botones,
  input  logic [3:0] estado,
  output logic [9:0] s,
  output logic       esperar,
  output logic       puerta_abierta
);

  typedef enum logic {
    CERRADA = 1'b0,
    ABIERTA = 1'b1
  } puerta_t;

  localparam logic [7:0] CNT_CARGA = 8'(TIEMPO_PUERTA - 1);

  puerta_t    state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [9:0] s_n;
  logic       mov_prev;
  logic       parada;
  logic [9:0] servido;

  logic       moviendo;
  logic       subiendo;
  logic [1:0] piso;

  assign moviendo = estado[3];
  assign subiendo = estado[2];
  assign piso     = estado[1:0];

  // A stop is a falling edge of the moving flag; mov_prev resets to 0 so the
  // first cycle after reset can never look like a stop.
  assign parada = mov_prev & ~moviendo;

  // Calls answered at the current floor in the current direction. The end
  // floors only have one hall button, answered regardless of direction.
  always_comb begin
    servido = '0;
    servido[6 + int'(piso)] = 1'b1;
    case (piso)
      2'd0: servido[0] = 1'b1;
      2'd1: begin
        if (subiendo) servido[2] = 1'b1;
        else          servido[1] = 1'b1;
      end
      2'd2: begin
        if (subiendo) servido[4] = 1'b1;
        else          servido[3] = 1'b1;
      end
      default: servido[5] = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    s_n     = s | botones;
    case (state)
      CERRADA: begin
        if (parada || (!moviendo && |(servido & (s | botones)))) begin
          state_n = ABIERTA;
          cnt_n   = CNT_CARGA;
          s_n     = (s | botones) & ~servido;
        end
      end
      ABIERTA: begin
        if (moviendo) begin
          state_n = CERRADA;
        end else begin
          // Served presses never latch while open; they only restart the timer.
          s_n = s | (botones & ~servido);
          if (|(botones & servido)) begin
            cnt_n = CNT_CARGA;
          end else if (cnt == 8'd0) begin
            state_n = CERRADA;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      default: state_n = CERRADA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CERRADA;
      cnt      <= '0;
      s        <= '0;
      mov_prev <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      s        <= s_n;
      mov_prev <= moviendo;
    end
  end

  assign esperar        = (state == ABIERTA);
  assign puerta_abierta = esperar;

endmodule

// File: tb/tb_registro_solicitudes.sv
// Directed bench for registro_solicitudes: a per-cycle reference model of the
// request/door rules plus literal expectations for each scenario.
module tb_registro_solicitudes;

  localparam int unsigned T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] botones = '0;
  logic [3:0] estado = '0;
  logic [9:0] s;
  logic       esperar;
  logic       puerta_abierta;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  registro_solicitudes #(.TIEMPO_PUERTA(T)) dut (
    .clk(clk),
    .rst(rst),
    .botones(botones),
    .estado(estado),
    .s(s),
    .esperar(esperar),
    .puerta_abierta(puerta_abierta)
  );

  always #5 clk = ~clk;

  // Reference model: m_left = door-open cycles still to go, including the current one.
  logic [9:0] m_s = '0;
  bit         m_open = 1'b0;
  int         m_left = 0;
  bit         m_prev = 1'b0;

  function automatic logic [9:0] served_of(input logic [1:0] f, input logic up);
    logic [9:0] r;
    int hall_down[4] = '{0, 1, 3, 5};
    int hall_up[4]   = '{0, 2, 4, 5};
    r = '0;
    r[6 + int'(f)] = 1'b1;
    if (up) r[hall_up[f]] = 1'b1;
    else    r[hall_down[f]] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    logic [9:0] srv;
    bit mv, stop;
    if (rst) begin
      m_s = '0; m_open = 0; m_left = 0; m_prev = 0;
    end else begin
      mv   = estado[3];
      srv  = served_of(estado[1:0], estado[2]);
      stop = m_prev && !mv;
      if (!m_open) begin
        if (stop || (!mv && ((m_s | botones) & srv) != 0)) begin
          m_open = 1; m_left = T;
          m_s = (m_s | botones) & ~srv;
        end else begin
          m_s = m_s | botones;
        end
      end else if (mv) begin
        m_open = 0;
        m_s = m_s | botones;
      end else begin
        m_s = m_s | (botones & ~srv);
        if ((botones & srv) != 0) m_left = T;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) m_open = 0;
        end
      end
      m_prev = mv;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model_s", 32'(s), 32'(m_s));
      chk("model_esperar", 32'(esperar), 32'(m_open));
      chk("model_puerta", 32'(puerta_abierta), 32'(m_open));
    end
  end

  task automatic cyc(input logic [9:0] b, input logic [3:0] e);
    botones = b;
    estado  = e;
    @(negedge clk);
  endtask

  task automatic count_open(input logic [3:0] e, output int n);
    n = 0;
    while (esperar === 1'b1 && n < 40) begin
      n++;
      cyc('0, e);
    end
  endtask

  initial begin
    int n;
    @(negedge clk);
    rst = 1'b1;
    cyc('0, 4'b0000);
    cyc('0, 4'b0000);
    rst = 1'b0;
    armed = 1'b1;
    chk("reset_s", 32'(s), 32'h0);
    chk("reset_esperar", 32'(esperar), 32'h0);

    // Latch a cabin call while moving.
    cyc(10'h100, 4'b1100);
    chk("latch_s", 32'(s), 32'h100);
    repeat (3) cyc('0, 4'b1100);
    chk("latch_hold", 32'(s), 32'h100);
    chk("latch_closed", 32'(esperar), 32'h0);

    // Stop at piso 2 going up.
    cyc(10'h084, 4'b1101);
    chk("stop_pre_s", 32'(s), 32'h184);
    cyc('0, 4'b0101);
    chk("stop_s", 32'(s), 32'h100);
    chk("stop_open", 32'(esperar), 32'h1);
    count_open(4'b0101, n);
    chk("door_time", 32'(n), 32'(T));

    // Direction filter, with a simultaneous new press on the clearing edge.
    cyc(10'h006, 4'b1101);
    cyc(10'h008, 4'b0101);
    chk("dirfilter_s", 32'(s), 32'h10A);
    chk("dirfilter_open", 32'(esperar), 32'h1);

    // Run down to cnt=3, latching a non-served call on the way, then re-extend.
    cyc('0, 4'b0101);
    cyc(10'h200, 4'b0101);
    cyc('0, 4'b0101);
    cyc('0, 4'b0101);
    cyc(10'h080, 4'b0101);
    chk("reext_s", 32'(s), 32'h30A);
    count_open(4'b0101, n);
    chk("reext_time", 32'(n), 32'(T));

    // Idle call at piso 1.
    cyc('0, 4'b0000);
    cyc('0, 4'b0000);
    chk("idle_closed", 32'(esperar), 32'h0);
    cyc(10'h001, 4'b0000);
    chk("idle_s", 32'(s), 32'h30A);
    chk("idle_open", 32'(esperar), 32'h1);
    count_open(4'b0000, n);
    chk("idle_time", 32'(n), 32'(T));

    // Motion while open closes immediately.
    cyc(10'h040, 4'b0000);
    chk("viol_open", 32'(esperar), 32'h1);
    cyc('0, 4'b1000);
    chk("viol_closed", 32'(esperar), 32'h0);
    chk("viol_s", 32'(s), 32'h30A);

    // Reset while open, with all buttons held through reset.
    cyc(10'h3FF, 4'b1110);
    chk("all_s", 32'(s), 32'h3FF);
    cyc('0, 4'b0110);
    chk("p3_s", 32'(s), 32'h2EF);
    chk("p3_open", 32'(esperar), 32'h1);
    rst = 1'b1;
    cyc(10'h3FF, 4'b1110);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_closed", 32'(esperar), 32'h0);
    rst = 1'b0;
    cyc('0, 4'b0110);
    chk("post_rst_s", 32'(s), 32'h0);
    chk("no_parada_after_rst", 32'(esperar), 32'h0);
    cyc('0, 4'b0110);

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/registro_solicitudes.md
REGISTRO_SOLICITUDES -- requirements
Module: registro_solicitudes

Interface
REQ-001 The block SHALL have parameter TIEMPO_PUERTA, default 8, giving the number of clock cycles the door stays open per service (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port botones, input, 10 bits: raw button presses, any pulse width.
- [0] piso 1 llamar-subir; [1] piso 2 bajar; [2] piso 2 subir; [3] piso 3 bajar; [4] piso 3 subir; [5] piso 4 bajar.
- [9:6] cabin buttons for pisos 4..1, with [6]=piso 1 and [9]=piso 4.
REQ-005 The block SHALL have port estado, input, 4 bits: elevator state, registered copy from the algorithm FSM.
- [3] moving=1; [2] subiendo=1; [1:0] floor, 00=piso 1 .. 11=piso 4.
REQ-006 The block SHALL have port s, output, 10 bits: latched pending requests, same bit map as botones.
REQ-007 The block SHALL have port esperar, output, 1 bit: high while the door is open; the algorithm FSM holds the elevator while it is high.
REQ-008 The block SHALL have port puerta_abierta, output, 1 bit: door actuator command, equal to esperar.

Function
REQ-009 Latching: each s[i] SHALL set on the cycle after botones[i] is sampled high, and SHALL stay set until cleared by REQ-013.
REQ-010 Stop detection: the block SHALL register estado[3] each cycle; the pattern previous=1, current=0 is a "parada".
REQ-011 Served set for floor f and direction d SHALL be:
- the cabin bit of f;
- the hall bit of f matching d: bajar if d=0, subir if d=1;
- at piso 1, s[0] regardless of d; at piso 4, s[5] regardless of d.
REQ-012 Door FSM SHALL have two states, CERRADA and ABIERTA, plus an 8-bit counter cnt.
REQ-013 CERRADA->ABIERTA SHALL occur on either trigger, in both cases loading cnt=TIEMPO_PUERTA-1 and clearing the served set for estado[1:0]/estado[2] on the same edge:
- a parada;
- estado[3]=0 with any served-set bit of the current floor set or pressed.
REQ-014 Latency: esperar SHALL rise exactly one cycle after the parada is sampled, and s SHALL show the served bits cleared on that same cycle.
REQ-015 In ABIERTA, cnt SHALL decrement each cycle; when cnt=0, the FSM SHALL return to CERRADA on the next edge, so esperar is high for exactly TIEMPO_PUERTA cycles.
REQ-016 A press of a served-set bit of the current floor while ABIERTA SHALL NOT latch, and SHALL reload cnt=TIEMPO_PUERTA-1 to re-extend the door time.
REQ-017 Presses of non-served bits while ABIERTA SHALL latch normally.
REQ-018 Simultaneous press and clear of the same bit on one edge: clear SHALL win.
REQ-019 Simultaneous press and clear of different bits on one edge: both SHALL take effect.
REQ-020 If estado[3] rises while ABIERTA (protocol violation), the FSM SHALL go to CERRADA on the next edge and clear nothing further.
REQ-021 cnt SHALL never wrap; decrement SHALL be suppressed at 0.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL set s=0, esperar=0, puerta_abierta=0, FSM=CERRADA, cnt=0, and registered estado[3]=0.
REQ-023 Presses sampled in a reset cycle SHALL be discarded.
REQ-024 Reset asserted mid-ABIERTA SHALL close the door on that edge.
REQ-025 No parada SHALL be detected on the first cycle after reset release.

Verification
REQ-026 Latch scenario: after reset, pulse botones[8] for 1 cycle with estado=1_1_00 -> s=10'h100 from the next cycle and held; esperar stays 0.
REQ-027 Stop and door-time scenario: s[7]=1 and s[2]=1, estado goes 1_1_01 -> 0_1_01 -> next cycle s[7]=0, s[2]=0, esperar=1 for exactly 8 cycles, then 0.
REQ-028 Direction-filter scenario: s[1]=1 and s[2]=1, parada at piso 2 subiendo -> only s[2] cleared, s[1] remains 1.
REQ-029 Re-extend scenario: door open with cnt=3, press botones[7] at piso 2 -> s[7] stays 0, esperar remains high for 8 further cycles.
REQ-030 Idle-call scenario: estado=0_0_00 idle, press botones[0] -> door opens next cycle, s[0] never observed set, esperar high for 8 cycles.
REQ-031 Reset scenario: assert rst during ABIERTA with s=10'h3FF -> next cycle s=0 and esperar=0; a press held during reset is not latched.
